aes_inv_key_schedule: RTL and testbench

// - Decryption-side key scheduler: the reverse walk of the AES-128 key expansion.
// - Takes the cipher key and rolls it forward to round key 10.
// - Then serves round keys 10,9,...,0 to the inverse cipher over a valid/ready handshake.
// - Each earlier key is recomputed backward on the fly; no 44-word array is stored.

---
 rtl/aes_pkg.sv | 54 +++++
 rtl/aes_sub_word.sv | 14 +
 rtl/aes_inv_key_schedule.sv | 133 +++++++++++++
 tb/tb_aes_inv_key_schedule.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES-128 constants and helpers shared by the key scheduler.
// Purely combinational content: S-box ROM, round constant table, FSM type.
// No flow control lives here.
package aes_pkg;

  localparam int AES128_NR = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FWD   = 2'd1,
    ST_SERVE = 2'd2
  } ks_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constants for rounds 1..10 (top byte of the Rcon word)
  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Rcon word for a round; rounds outside 1..10 contribute nothing
  function automatic logic [31:0] rcon_word(input logic [3:0] round);
    logic [31:0] w;
    w = 32'h0;
    if (round >= 4'd1 && round <= 4'd10) w = {RCON[round], 24'h0};
    return w;
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// 32-bit AES SubWord: four byte-wide S-box lookups in parallel.
// Latency: combinational, zero cycles.
// No flow control; output follows input.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  // One S-box ROM per byte lane
  always_comb word_o = sub_word(word_i);

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 decryption key scheduler: rolls the cipher key forward to round 10, then serves 10..0 recomputing backward.
// Latency: first key valid 10 cycles after start (0 with PRECOMPUTE_LAST), then one key per cycle.
// Backpressure: rk/rk_round hold while rk_valid & ~rk_ready; no internal buffering.
module aes_inv_key_schedule
  import aes_pkg::*;
#(
  parameter int NR              = AES128_NR,  // only 10 is meaningful
  parameter bit PRECOMPUTE_LAST = 1'b0
) (
  input  logic         ACLK,
  input  logic         ARST,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  output logic         done
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  ks_state_e    state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   round_q, round_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;

  logic [31:0]  w_a, w_b, w_c, w_d;
  logic [31:0]  bw_w3;
  logic [31:0]  sw_in, sw_out;
  logic [31:0]  fw_a, fw_b, fw_c, fw_d;
  logic [31:0]  bw_w0;
  logic         hs;

  assign {w_a, w_b, w_c, w_d} = rk_q;
  assign hs = valid_q & rk_ready;

  // Backward step recovers the last word of the previous round first; it feeds the shared SubWord
  assign bw_w3 = w_d ^ w_c;

  // Share the single SubWord unit: last word forward, recovered last word backward
  always_comb sw_in = (state_q == ST_SERVE) ? rot_word(bw_w3) : rot_word(w_d);

  aes_sub_word u_sub_word (
    .word_i (sw_in),
    .word_o (sw_out)
  );

  // Forward round step produces round (round_q + 1)
  always_comb begin
    fw_a = w_a ^ sw_out ^ rcon_word(round_q + 4'd1);
    fw_b = w_b ^ fw_a;
    fw_c = w_c ^ fw_b;
    fw_d = w_d ^ fw_c;
  end

  // Backward round step undoes round round_q
  always_comb bw_w0 = w_a ^ sw_out ^ rcon_word(round_q);

  // Next-state and next-key selection
  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    round_d = round_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rk_d = key;
          if (PRECOMPUTE_LAST) begin
            round_d = LAST_ROUND;
            valid_d = 1'b1;
            state_d = ST_SERVE;
          end else begin
            round_d = 4'd0;
            state_d = ST_FWD;
          end
        end
      end
      ST_FWD: begin
        rk_d    = {fw_a, fw_b, fw_c, fw_d};
        round_d = round_q + 4'd1;
        if (round_q == LAST_ROUND - 4'd1) begin
          valid_d = 1'b1;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (hs) begin
          if (round_q == 4'd0) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            rk_d    = {bw_w0, w_b ^ w_a, w_c ^ w_b, bw_w3};
            round_d = round_q - 4'd1;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // All scheduler state, cleared asynchronously from any state
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      state_q <= ST_IDLE;
      rk_q    <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign rk_valid = valid_q;
  assign rk       = rk_q;
  assign rk_round = round_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Self-checking bench for aes_inv_key_schedule: known-answer table plus random keys and stalls.
// Reference model: textbook forward key expansion with a GF(2^8)-derived S-box.
// Two instances cover PRECOMPUTE_LAST = 0 and 1.
module tb_aes_inv_key_schedule;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         arst;
  logic         start;
  logic         rk_ready;
  logic [127:0] key;
  bit           use_pc;

  logic start0, start1, rdy0, rdy1;
  logic busy0, busy1, v0, v1, done0, done1;
  logic [127:0] rk0, rk1;
  logic [3:0]   rr0, rr1;

  assign start0 = start & ~use_pc;
  assign start1 = start & use_pc;
  assign rdy0   = rk_ready & ~use_pc;
  assign rdy1   = rk_ready & use_pc;

  logic         m_busy, m_valid, m_done;
  logic [127:0] m_rk;
  logic [3:0]   m_round;
  assign m_busy  = use_pc ? busy1 : busy0;
  assign m_valid = use_pc ? v1 : v0;
  assign m_done  = use_pc ? done1 : done0;
  assign m_rk    = use_pc ? rk1 : rk0;
  assign m_round = use_pc ? rr1 : rr0;

  aes_inv_key_schedule #(.NR(10), .PRECOMPUTE_LAST(1'b0)) dut0 (
    .ACLK(clk), .ARST(arst), .start(start0), .key(key), .busy(busy0), .rk_valid(v0),
    .rk_ready(rdy0), .rk(rk0), .rk_round(rr0), .done(done0)
  );

  aes_inv_key_schedule #(.NR(10), .PRECOMPUTE_LAST(1'b1)) dut1 (
    .ACLK(clk), .ARST(arst), .start(start1), .key(key), .busy(busy1), .rk_valid(v1),
    .rk_ready(rdy1), .rk(rk1), .rk_round(rr1), .done(done1)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [0:10];
  logic [127:0] got_rk [0:10];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // S-box from first principles: multiplicative inverse then affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Full 44-word forward expansion, round keys stored for lookup
  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // One full schedule; starts on the current negedge, ends on the negedge showing done
  task automatic run_schedule(input logic [127:0] k, input bit pc, input int stall_pct, input bit inject);
    int cnt;
    int serve_cycles;
    logic [3:0] exp_round;
    bit fin;
    model_expand(k);
    use_pc   = pc;
    key      = pc ? exp_rk[10] : k;
    rk_ready = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key   = ~key;
    chk("busy_after_start", m_busy, 1'b1);
    chk("done_low_after_start", m_done, 1'b0);
    cnt = 0;
    while (!m_valid && cnt < 40) begin
      start = (inject && cnt == 3);
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    chk("first_valid_latency", cnt, pc ? 0 : 10);
    exp_round    = 4'd10;
    serve_cycles = 0;
    fin          = 1'b0;
    while (!fin && serve_cycles < 300) begin
      rk_ready = ($urandom_range(0, 99) < stall_pct) ? 1'b0 : 1'b1;
      start    = inject && rk_ready && (exp_round == 4'd6 || exp_round == 4'd0);
      chk("rk_valid_in_serve", m_valid, 1'b1);
      chk("rk_round", m_round, exp_round);
      chk($sformatf("rk_round%0d", exp_round), m_rk, exp_rk[exp_round]);
      if (rk_ready) got_rk[exp_round] = m_rk;
      @(negedge clk);
      serve_cycles++;
      if (rk_ready) begin
        if (exp_round == 4'd0) fin = 1'b1;
        else exp_round = exp_round - 4'd1;
      end
    end
    rk_ready = 1'b0;
    start    = 1'b0;
    chk("serve_completed", fin, 1'b1);
    chk("done_pulse", m_done, 1'b1);
    chk("valid_low_after_done", m_valid, 1'b0);
    chk("idle_after_done", m_busy, 1'b0);
    chk("rk_holds_round0", m_rk, exp_rk[0]);
    if (stall_pct == 0) chk("zero_bubble_cycles", serve_cycles, 11);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] r10;
    logic [127:0] r1;
    int           stall;
    bit           inject;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int g;
    arst = 1'b1; start = 1'b0; rk_ready = 1'b0; key = '0; use_pc = 1'b0;
    build_sbox();
    repeat (3) @(negedge clk);
    chk("reset_busy0", busy0, 1'b0);
    chk("reset_valid0", v0, 1'b0);
    chk("reset_rk0", rk0, 128'h0);
    chk("reset_round0", rr0, 4'd0);
    chk("reset_done0", done0, 1'b0);
    chk("reset_valid1", v1, 1'b0);
    chk("reset_rk1", rk1, 128'h0);
    arst = 1'b0;
    @(negedge clk);

    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                128'ha0fafe1788542cb123a339392a6c7605, 0, 1'b0};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                128'ha0fafe1788542cb123a339392a6c7605, 50, 1'b0};
    vecs[2] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h13111d7fe3944a17f307a78b4d2b30c5,
                128'hd6aa74fdd2af72fadaa678f1d6ab76fe, 30, 1'b1};
    vecs[3] = '{128'h00000000000000000000000000000000, 128'hb4ef5bcb3e92e21123e951cf6f8f188e,
                128'h62636363626363636263636362636363, 0, 1'b0};
    vecs[4] = '{128'hffffffffffffffffffffffffffffffff, 128'hd60a3588e472f07b82d2d7858cd7c326,
                128'he8e9e9e917161616e8e9e9e917161616, 25, 1'b1};

    // Known-answer schedules, each started right after the previous done
    for (int i = 0; i < 5; i++) begin
      run_schedule(vecs[i].key, 1'b0, vecs[i].stall, vecs[i].inject);
      chk($sformatf("kat%0d_r10", i), got_rk[10], vecs[i].r10);
      chk($sformatf("kat%0d_r1", i), got_rk[1], vecs[i].r1);
      chk($sformatf("kat%0d_r0", i), got_rk[0], vecs[i].key);
    end

    // Key input already round 10
    run_schedule(vecs[0].key, 1'b1, 20, 1'b1);
    chk("pc_last_key", got_rk[0], vecs[0].key);
    chk("pc_first_key", got_rk[10], vecs[0].r10);

    // Async reset in the middle of serving
    use_pc = 1'b0;
    @(negedge clk);
    model_expand(vecs[2].key);
    key = vecs[2].key; rk_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (!(v0 && rr0 == 4'd5) && g < 60) begin
      @(negedge clk);
      g++;
    end
    chk("reached_round5", {v0, rr0}, {1'b1, 4'd5});
    chk("round5_key", rk0, exp_rk[5]);
    rk_ready = 1'b0;
    #2 arst = 1'b1;
    #1;
    chk("arst_busy", busy0, 1'b0);
    chk("arst_valid", v0, 1'b0);
    chk("arst_rk", rk0, 128'h0);
    chk("arst_round", rr0, 4'd0);
    chk("arst_done", done0, 1'b0);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    chk("no_done_after_arst", done0, 1'b0);
    run_schedule(vecs[3].key, 1'b0, 10, 1'b0);

    // Random keys and stall rates
    for (int i = 0; i < 4; i++)
      run_schedule({$urandom, $urandom, $urandom, $urandom}, i[0], $urandom_range(0, 60), i[1]);

    @(negedge clk);
    chk("done_single_cycle", m_done, 1'b0);
    chk("final_idle", m_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
